// File: rtl/caravel_open_frame.sv
`timescale 1ns/1ps
// caravel_open_frame
//
// Simplified openframe chip top used by the gpio_vector test. There is no CPU:
// a prescaled 8-bit up-counter (the "GPIO vector") is driven onto gpio[23:16].
// The flash interface pins are parked idle. Optionally, a UART transmitter on
// gpio[6] reports each new counter value.
//
// Build option:
//   UART_MSG_EN  when defined, adds the 8N1 UART transmitter on gpio[6].
//                When undefined, gpio[6] is left high-Z and no UART logic exists.
//
// Parameters:
//   DIV       clock cycles per counter step (>= 2)
//   UART_DIV  clock cycles per UART bit (>= 2); only used with UART_MSG_EN
//
// Ports:
//   gpio[43:0]  pad bus
//                 [38]    clock input (never driven here)
//                 [3]     housekeeping CSB input (ignored)
//                 [23:16] counter value, always driven (0 while in reset)
//                 [39]    flash CSB, held 1 (deselected)
//                 [40]    flash clock, held 0
//                 [6]     UART Tx (UART_MSG_EN) or high-Z
//                 others  high-Z
//   resetb      asynchronous assert, active-low reset; release is synchronised
//   vddio, vssio, vccd, vssd  supply ties, functionally ignored
module caravel_open_frame #(
  parameter int DIV      = 256,
  parameter int UART_DIV = 16
) (
  inout  wire  [43:0] gpio,
  input  logic        resetb,
  input  logic        vddio,
  input  logic        vssio,
  input  logic        vccd,
  input  logic        vssd
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Modulo-256 increment of the GPIO vector.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  logic clk;
  assign clk = gpio[38];

  // Supply ties and input-only pads carry no function in this block.
  wire unused_pins;
  assign unused_pins = &{1'b0, vddio, vssio, vccd, vssd, gpio};

  // ---- Reset synchroniser: assert asynchronously, release on the second edge
  logic sync1_p0;
  logic sync2_p0;
  logic rst;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_p0 <= 1'b0;
      sync2_p0 <= 1'b0;
    end else begin
      sync1_p0 <= 1'b1;
      sync2_p0 <= sync1_p0;
    end
  end

  // Internal synchronous reset, active-high, held until the synchroniser releases.
  assign rst = !sync2_p0;

  // ---- Prescaler and counter stage
  logic [PRE_W-1:0] pre_p0;
  logic [7:0]       cnt_p0;
  logic             tick;
  logic [7:0]       cnt_nxt;

  assign tick    = !rst && (pre_p0 == PRE_W'(DIV - 1));
  assign cnt_nxt = wrap_inc(cnt_p0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pre_p0 <= '0;
    end else if (rst) begin
      pre_p0 <= '0;
    end else if (tick) begin
      pre_p0 <= '0;
    end else begin
      pre_p0 <= pre_p0 + 1'b1;
    end
  end

  // The counter is also the pad register, so gpio[23:16] changes on the
  // same edge as the count with no extra latency.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_p0 <= 8'd0;
    end else if (rst) begin
      cnt_p0 <= 8'd0;
    end else if (tick) begin
      cnt_p0 <= cnt_nxt;
    end
  end

  // ---- Static pad map
  assign gpio[23:16] = cnt_p0;
  assign gpio[39]    = 1'b1;
  assign gpio[40]    = 1'b0;

  assign gpio[43:41] = 3'bzzz;
  assign gpio[37:24] = {14{1'bz}};
  assign gpio[15:7]  = {9{1'bz}};
  assign gpio[5:4]   = 2'bzz;
  assign gpio[2:0]   = 3'bzzz;

`ifdef UART_MSG_EN
  // ---- UART transmit stage (8N1, LSB first)
  localparam int BAUD_W = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;

  logic              busy_p1;
  logic [3:0]        bit_p1;
  logic [BAUD_W-1:0] baud_p1;
  logic              tx_p1;
  logic [8:0]        shreg_p1;
  logic              load;
  logic              bit_end;

  // A tick while a frame is in flight is simply dropped: there is no queue.
  assign load    = tick && !busy_p1;
  assign bit_end = busy_p1 && (baud_p1 == BAUD_W'(UART_DIV - 1));

  // bit_p1 indexes the frame: 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      busy_p1 <= 1'b0;
      bit_p1  <= 4'd0;
      baud_p1 <= '0;
      tx_p1   <= 1'b1;
    end else if (rst) begin
      busy_p1 <= 1'b0;
      bit_p1  <= 4'd0;
      baud_p1 <= '0;
      tx_p1   <= 1'b1;
    end else if (load) begin
      busy_p1 <= 1'b1;
      bit_p1  <= 4'd0;
      baud_p1 <= '0;
      tx_p1   <= 1'b0;
    end else if (bit_end) begin
      baud_p1 <= '0;
      if (bit_p1 == 4'd9) begin
        busy_p1 <= 1'b0;
        tx_p1   <= 1'b1;
      end else begin
        bit_p1 <= bit_p1 + 4'd1;
        tx_p1  <= shreg_p1[0];
      end
    end else if (busy_p1) begin
      baud_p1 <= baud_p1 + 1'b1;
    end
  end

  // Data plus stop bit; only ever read after a load, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg_p1 <= {1'b1, cnt_nxt};
    end else if (bit_end && (bit_p1 != 4'd9)) begin
      shreg_p1 <= {1'b1, shreg_p1[8:1]};
    end
  end

  assign gpio[6] = tx_p1;
`else
  localparam int unused_uart_div = UART_DIV;

  assign gpio[6] = 1'bz;
`endif

endmodule

// File: tb/tb_caravel_open_frame.sv
`timescale 1ns/1ps
module tb_caravel_open_frame;

  localparam int DIV_A = 64;
  localparam int UD_A  = 4;
  localparam int DIV_B = 25;
  localparam int UD_B  = 4;

  logic clk    = 1'b0;
  logic resetb = 1'b0;
  logic hk_csb = 1'b1;
  logic vddio  = 1'b1;
  logic vssio  = 1'b0;
  logic vccd   = 1'b1;
  logic vssd   = 1'b0;

  wire [43:0] gpio_a;
  wire [43:0] gpio_b;

  assign gpio_a[38] = clk;
  assign gpio_a[3]  = hk_csb;
  assign gpio_b[38] = clk;
  assign gpio_b[3]  = hk_csb;

  caravel_open_frame #(.DIV(DIV_A), .UART_DIV(UD_A)) dut_a (
    .gpio(gpio_a), .resetb(resetb),
    .vddio(vddio), .vssio(vssio), .vccd(vccd), .vssd(vssd)
  );

  caravel_open_frame #(.DIV(DIV_B), .UART_DIV(UD_B)) dut_b (
    .gpio(gpio_b), .resetb(resetb),
    .vddio(vddio), .vssio(vssio), .vccd(vccd), .vssd(vssd)
  );

  always #12.5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m = 0;        // falling edges since resetb last rose
  int cyc = 0;      // free-running rising-edge count
  int rel_cyc = 0;  // value of cyc at the internal reset release edge

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: internal reset releases on the 2nd rising edge after resetb
  // rises; value n is visible from n*div cycles after that release.
  function automatic int exp_cnt(input int mm, input int div);
    if (mm < 2) return 0;
    return ((mm - 2) / div) % 256;
  endfunction

  task automatic step();
    @(negedge clk);
    m++;
  endtask

`ifdef UART_MSG_EN
  typedef struct {
    logic [7:0] data;
    int         start;
    logic       stop;
  } frame_t;

  frame_t qa[$];
  frame_t qb[$];

  function automatic logic rx(input int which);
    return (which == 0) ? gpio_a[6] : gpio_b[6];
  endfunction

  // Serial receiver: samples each bit in its middle on falling edges.
  task automatic uart_rx(input int which, input int ud, output frame_t f);
    do @(negedge clk); while (rx(which) !== 1'b0);
    f.start = cyc;
    repeat (ud / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (ud) @(negedge clk);
      f.data[i] = rx(which);
    end
    repeat (ud) @(negedge clk);
    f.stop = rx(which);
  endtask

  always begin : rx_a
    frame_t f;
    uart_rx(0, UD_A, f);
    qa.push_back(f);
  end

  always begin : rx_b
    frame_t f;
    uart_rx(1, UD_B, f);
    qb.push_back(f);
  end
`endif

  task automatic release_reset();
    @(negedge clk);
    resetb  = 1'b1;
    m       = 0;
    rel_cyc = cyc + 2;
`ifdef UART_MSG_EN
    qa.delete();
    qb.delete();
`endif
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (80) begin
      @(negedge clk);
      checks++;
      if (gpio_a[23:16] !== 8'h00) begin
        errors++;
        $display("FAIL reset_cnt_a got %h want 00", gpio_a[23:16]);
      end
      checks++;
      if (gpio_b[23:16] !== 8'h00) begin
        errors++;
        $display("FAIL reset_cnt_b got %h want 00", gpio_b[23:16]);
      end
      checks++;
      if (gpio_a[39] !== 1'b1 || gpio_a[40] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flash got csb=%b clk=%b want csb=1 clk=0", gpio_a[39], gpio_a[40]);
      end
`ifdef UART_MSG_EN
      checks++;
      if (gpio_a[6] !== 1'b1) begin
        errors++;
        $display("FAIL reset_tx got %b want 1", gpio_a[6]);
      end
`endif
    end
  endtask

  task automatic test_count();
    int first33 = -1;
    release_reset();
    repeat (40 * DIV_A) begin
      step();
      checks++;
      if (gpio_a[23:16] !== 8'(exp_cnt(m, DIV_A))) begin
        errors++;
        $display("FAIL count_a m=%0d got %h want %h", m, gpio_a[23:16], 8'(exp_cnt(m, DIV_A)));
      end
      checks++;
      if (gpio_b[23:16] !== 8'(exp_cnt(m, DIV_B))) begin
        errors++;
        $display("FAIL count_b m=%0d got %h want %h", m, gpio_b[23:16], 8'(exp_cnt(m, DIV_B)));
      end
      if (first33 < 0 && gpio_a[23:16] === 8'd33) first33 = m;
    end
    checks++;
    if (first33 != 2 + 33 * DIV_A) begin
      errors++;
      $display("FAIL count_33 got first at %0d want %0d", first33, 2 + 33 * DIV_A);
    end
    checks++;
    if (gpio_a[39] !== 1'b1 || gpio_a[40] !== 1'b0) begin
      errors++;
      $display("FAIL run_flash got csb=%b clk=%b want csb=1 clk=0", gpio_a[39], gpio_a[40]);
    end
  endtask

`ifdef UART_MSG_EN
  task automatic test_uart();
    int div, ud, now, last, k, t;
    logic [7:0] want;
    for (int which = 0; which < 2; which++) begin
      div  = (which == 0) ? DIV_A : DIV_B;
      ud   = (which == 0) ? UD_A : UD_B;
      now  = cyc - rel_cyc;
      last = -1000000;
      k    = 0;
      for (int n = 1; n * div + 10 * ud <= now; n++) begin
        t = n * div;
        if (t - last >= 10 * ud) begin
          last = t;
          want = 8'(n % 256);
          checks++;
          if (k >= ((which == 0) ? qa.size() : qb.size())) begin
            errors++;
            $display("FAIL uart%0d_missing frame %0d got none want %h", which, k, want);
          end else begin
            frame_t f;
            f = (which == 0) ? qa[k] : qb[k];
            checks++;
            if (f.data !== want) begin
              errors++;
              $display("FAIL uart%0d_data frame %0d got %h want %h", which, k, f.data, want);
            end
            checks++;
            if (f.start != rel_cyc + t) begin
              errors++;
              $display("FAIL uart%0d_start frame %0d got %0d want %0d", which, k, f.start, rel_cyc + t);
            end
            checks++;
            if (f.stop !== 1'b1) begin
              errors++;
              $display("FAIL uart%0d_stop frame %0d got %b want 1", which, k, f.stop);
            end
          end
          k++;
        end
      end
    end
  endtask
`endif

  task automatic test_wrap();
    logic [7:0] prev;
    int seen_ff00 = 0;
    int seen_0001 = 0;
    prev = gpio_a[23:16];
    while (m < 2 + 258 * DIV_A + 4) begin
      step();
      checks++;
      if (gpio_a[23:16] !== 8'(exp_cnt(m, DIV_A))) begin
        errors++;
        $display("FAIL wrap_a m=%0d got %h want %h", m, gpio_a[23:16], 8'(exp_cnt(m, DIV_A)));
      end
      checks++;
      if (gpio_b[23:16] !== 8'(exp_cnt(m, DIV_B))) begin
        errors++;
        $display("FAIL wrap_b m=%0d got %h want %h", m, gpio_b[23:16], 8'(exp_cnt(m, DIV_B)));
      end
      if (prev === 8'hFF && gpio_a[23:16] === 8'h00) seen_ff00++;
      if (seen_ff00 > 0 && prev === 8'h00 && gpio_a[23:16] === 8'h01) seen_0001++;
      prev = gpio_a[23:16];
    end
    checks++;
    if (seen_ff00 != 1 || seen_0001 != 1) begin
      errors++;
      $display("FAIL wrap_seq got ff->00 x%0d, 00->01 x%0d want 1 and 1", seen_ff00, seen_0001);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (exp_cnt(m, DIV_A) != 8'h12 && guard < 300 * DIV_A) begin
      step();
      guard++;
      checks++;
      if (gpio_a[23:16] !== 8'(exp_cnt(m, DIV_A))) begin
        errors++;
        $display("FAIL pre_mid_a m=%0d got %h want %h", m, gpio_a[23:16], 8'(exp_cnt(m, DIV_A)));
      end
    end
    checks++;
    if (gpio_a[23:16] !== 8'h12) begin
      errors++;
      $display("FAIL mid_reach got %h want 12", gpio_a[23:16]);
    end
    step();
    #2 resetb = 1'b0;
    #1;
    checks++;
    if (gpio_a[23:16] !== 8'h00 || gpio_b[23:16] !== 8'h00) begin
      errors++;
      $display("FAIL mid_async got a=%h b=%h want 00 00", gpio_a[23:16], gpio_b[23:16]);
    end
`ifdef UART_MSG_EN
    checks++;
    if (gpio_a[6] !== 1'b1) begin
      errors++;
      $display("FAIL mid_tx_abort got %b want 1", gpio_a[6]);
    end
`endif
    release_reset();
    repeat (3 * DIV_A + 8) begin
      step();
      checks++;
      if (gpio_a[23:16] !== 8'(exp_cnt(m, DIV_A))) begin
        errors++;
        $display("FAIL post_mid_a m=%0d got %h want %h", m, gpio_a[23:16], 8'(exp_cnt(m, DIV_A)));
      end
      checks++;
      if (gpio_b[23:16] !== 8'(exp_cnt(m, DIV_B))) begin
        errors++;
        $display("FAIL post_mid_b m=%0d got %h want %h", m, gpio_b[23:16], 8'(exp_cnt(m, DIV_B)));
      end
    end
  endtask

  initial begin
    #(25.0 * 60000);
    $display("FAIL timeout after 60000 cycles got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    hk_csb = 1'b1;
    test_reset();
    test_count();
`ifdef UART_MSG_EN
    test_uart();
`endif
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
